// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Multicycle control unit for the IF/EX/WB datapath. Each instruction is
// latched into an internal IR and stepped through FETCH, DECODE, EXECUTE,
// (MEM) and WRITEBACK. All datapath enables and mux selects are Moore
// outputs: they are registered from the next state and next IR, so after
// every clock edge they reflect only the current state and the latched IR.
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous, active-high reset; clears every output at once
//   instruction  instruction word from IF, latched at the end of FETCH
//   tf_out       test-flag result from EX, sampled at the end of EXECUTE
//   dm_ready     data memory done, only looked at in MEM
//   W_IR         instruction register load (FETCH)
//   W_PC         PC write (WB)
//   S_MXPC       PC source: 00 = PC+1, 01 = branch target
//   mxse_SMXSE   ALU B source: 0 = register, 1 = sign-extended immediate
//   alu_OPALU    ALU operation
//   tf_OPTF      test-flag condition
//   rf_WRF       register-file write
//   WFLAGS       flag register write
//   RDM          data memory read request (load in MEM)
//   dm_WDM       data memory write request (store in MEM)
//   mxrb_SMXRB   writeback source: 00 = ALU, 01 = DM, 10 = next PC
//   halted       processor stopped by the all-ones HALT word
//   instr_count  retired instructions (WB count), wraps
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module control_sequencer #(
    parameter int IW   = 32,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [IW-1:0]   instruction,
    input  logic            tf_out,
    input  logic            dm_ready,
    output logic            W_IR,
    output logic            W_PC,
    output logic [1:0]      S_MXPC,
    output logic            mxse_SMXSE,
    output logic [4:0]      alu_OPALU,
    output logic [3:0]      tf_OPTF,
    output logic            rf_WRF,
    output logic            WFLAGS,
    output logic            RDM,
    output logic            dm_WDM,
    output logic [1:0]      mxrb_SMXRB,
    output logic            halted,
    output logic [CNTW-1:0] instr_count
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_MEM  = 2'b01,
        CLS_JUMP = 2'b10,
        CLS_RSVD = 2'b11
    } class_t;

    typedef struct packed {
        logic       w_ir;
        logic       w_pc;
        logic [1:0] s_mxpc;
        logic       smxse;
        logic [4:0] opalu;
        logic [3:0] optf;
        logic       wrf;
        logic       wflags;
        logic       rdm;
        logic       wdm;
        logic [1:0] smxrb;
        logic       halted;
    } ctrl_t;

    localparam logic [4:0] ALU_ADD = 5'h00;

    state_t          r_state;
    logic [IW-1:0]   r_ir;
    logic            r_taken;
    logic [CNTW-1:0] r_count;
    ctrl_t           r_out;

    state_t          w_next_state;
    logic [IW-1:0]   w_next_ir;
    logic            w_next_taken;
    class_t          w_cls;
    logic            w_is_halt;
    ctrl_t           w_out;
    class_t          w_next_cls;
    logic            w_next_load;
    logic            w_next_link;

    assign w_cls     = class_t'(r_ir[31:30]);
    assign w_is_halt = &r_ir;

    // Next-state, next-IR and branch-taken flag.
    // NOTE: every signal assigned in an always_comb gets a default at the
    // top so that no path through the case leaves it unassigned (latch).
    always_comb begin
        w_next_state = r_state;
        w_next_ir    = r_ir;
        w_next_taken = r_taken;
        case (r_state)
            ST_INIT:    w_next_state = ST_FETCH;
            ST_FETCH: begin
                w_next_ir    = instruction;
                w_next_state = ST_DECODE;
            end
            ST_DECODE:  w_next_state = w_is_halt ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE: begin
                w_next_taken = (w_cls == CLS_JUMP) && tf_out;
                w_next_state = (w_cls == CLS_MEM) ? ST_MEM : ST_WB;
            end
            ST_MEM:     if (dm_ready) w_next_state = ST_WB;
            ST_WB:      w_next_state = ST_FETCH;
            ST_HALT:    w_next_state = ST_HALT;
            default:    w_next_state = ST_INIT;   // illegal encoding recovers
        endcase
    end

    // Output decode for the state being entered; registering it makes the
    // outputs a pure function of the (new) state and latched IR.
    assign w_next_cls  = class_t'(w_next_ir[31:30]);
    assign w_next_load = ~w_next_ir[29];
    assign w_next_link = w_next_ir[25];

    always_comb begin
        w_out = '0;
        case (w_next_state)
            ST_FETCH: w_out.w_ir = 1'b1;
            ST_EXECUTE: begin
                case (w_next_cls)
                    CLS_ALU: begin
                        w_out.opalu = w_next_ir[29:25];
                        w_out.smxse = w_next_ir[24];
                    end
                    CLS_MEM: begin
                        w_out.opalu = ALU_ADD;
                        w_out.smxse = 1'b1;
                    end
                    CLS_JUMP: w_out.optf = w_next_ir[29:26];
                    default:  ;
                endcase
            end
            ST_MEM: begin
                // Address computation stays driven for the whole access.
                w_out.opalu = ALU_ADD;
                w_out.smxse = 1'b1;
                w_out.rdm   = w_next_load;
                w_out.wdm   = ~w_next_load;
            end
            ST_WB: begin
                w_out.w_pc   = 1'b1;
                w_out.s_mxpc = {1'b0, w_next_taken};
                case (w_next_cls)
                    CLS_ALU: begin
                        w_out.wrf    = 1'b1;
                        w_out.wflags = 1'b1;
                        w_out.smxrb  = 2'b00;
                    end
                    CLS_MEM: begin
                        w_out.wrf   = w_next_load;
                        w_out.smxrb = w_next_load ? 2'b01 : 2'b00;
                    end
                    CLS_JUMP: begin
                        w_out.wrf   = w_next_link;
                        w_out.smxrb = w_next_link ? 2'b10 : 2'b00;
                    end
                    default: ;
                endcase
            end
            ST_HALT: w_out.halted = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_INIT;
            r_ir    <= '0;
            r_taken <= 1'b0;
            r_count <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ir    <= w_next_ir;
            r_taken <= w_next_taken;
            r_out   <= w_out;
            if (r_state == ST_WB) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign W_IR        = r_out.w_ir;
    assign W_PC        = r_out.w_pc;
    assign S_MXPC      = r_out.s_mxpc;
    assign mxse_SMXSE  = r_out.smxse;
    assign alu_OPALU   = r_out.opalu;
    assign tf_OPTF     = r_out.optf;
    assign rf_WRF      = r_out.wrf;
    assign WFLAGS      = r_out.wflags;
    assign RDM         = r_out.rdm;
    assign dm_WDM      = r_out.wdm;
    assign mxrb_SMXRB  = r_out.smxrb;
    assign halted      = r_out.halted;
    assign instr_count = r_count;

endmodule
